// File: rtl/common_types_pkg.sv
// Shared scalar types plus the writeback-stage load/FSM types.
package common_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [2:0] {LB, LH, LW, LBU, LHU} load_type_t;
  typedef enum logic       {IDLE, WAIT_LOAD}     wb_state_t;

  // Load context held while the data-memory response is outstanding
  typedef struct packed {
    regbits_t   rd;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
  } load_req_t;

  // Undefined width encodings (011, 110, 111) fall back to a full word
  function automatic load_type_t decode_load(input logic [2:0] f3);
    case (f3)
      3'b000:  return LB;
      3'b001:  return LH;
      3'b100:  return LBU;
      3'b101:  return LHU;
      default: return LW;
    endcase
  endfunction
endpackage

// File: rtl/register_file_if.sv
// Register-file write port; the register file samples it on the falling edge.
interface register_file_if;
  import common_types_pkg::*;
  logic     wen;
  regbits_t wsel;
  word_t    wdat;
  modport writeback (output wen, wsel, wdat);
  modport regfile   (input  wen, wsel, wdat);
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half of a load word and sign/zero-extends it.
module load_align
  import common_types_pkg::*;
(
  input  word_t      word,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  output word_t      ext
);
  logic [7:0]  b;
  logic [15:0] h;

  // Lane select then extension; half lane ignores addr_lo[0]
  always_comb begin
    b = word[{addr_lo, 3'b000} +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (decode_load(funct3))
      LB:      ext = {{24{b[7]}}, b};
      LBU:     ext = {24'h0, b};
      LH:      ext = {{16{h[15]}}, h};
      LHU:     ext = {16'h0, h};
      default: ext = word;
    endcase
  end
endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires ALU results directly, waits for load data,
// and drives a registered register-file write port.
module writeback_stage
  import common_types_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic [31:0] in_result,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_wsel,
  output logic [31:0] rf_wdat,
  output logic        pending_valid,
  output logic [4:0]  pending_rd,
  output logic        bus_err,
  output logic [31:0] retire_count
);
  localparam int             CW      = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

  wb_state_t      state;
  load_req_t      req;
  logic [CW-1:0]  cnt;
  word_t          ld_word;
  logic           acc_alu, acc_ld, ld_done, ld_tmo;

  register_file_if rf_if ();

  load_align u_align (
    .word    (dmem_rdata),
    .funct3  (req.funct3),
    .addr_lo (req.addr_lo),
    .ext     (ld_word)
  );

  assign in_ready      = (state == IDLE);
  assign acc_alu       = in_ready && in_valid && !in_is_load;
  assign acc_ld        = in_ready && in_valid && in_is_load;
  // Response wins over a timeout landing on the same edge
  assign ld_done       = (state == WAIT_LOAD) && dmem_rvalid;
  assign ld_tmo        = (state == WAIT_LOAD) && !dmem_rvalid && (cnt == TO_LAST);
  assign pending_valid = (state == WAIT_LOAD) && (req.rd != 5'd0);
  assign pending_rd    = pending_valid ? req.rd : 5'd0;

  assign rf_wen  = rf_if.wen;
  assign rf_wsel = rf_if.wsel;
  assign rf_wdat = rf_if.wdat;

  // Load FSM: latch load context, count wait cycles, abort on timeout
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      req     <= '0;
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= ld_tmo;
      if (acc_ld) begin
        state <= WAIT_LOAD;
        req   <= '{rd: in_rd, funct3: in_funct3, addr_lo: in_addr_lo};
        cnt   <= '0;
      end else if (ld_done || ld_tmo) begin
        state <= IDLE;
      end else if (state == WAIT_LOAD) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Registered write port and retire counter; x0 retires but never writes
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rf_if.wen    <= 1'b0;
      rf_if.wsel   <= '0;
      rf_if.wdat   <= '0;
      retire_count <= '0;
    end else begin
      rf_if.wen <= 1'b0;
      if (acc_alu) begin
        rf_if.wen    <= (in_rd != 5'd0);
        rf_if.wsel   <= in_rd;
        rf_if.wdat   <= in_result;
        retire_count <= retire_count + 32'd1;
      end else if (ld_done) begin
        rf_if.wen    <= (req.rd != 5'd0);
        rf_if.wsel   <= req.rd;
        rf_if.wdat   <= ld_word;
        retire_count <= retire_count + 32'd1;
      end
    end
  end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage that retires instructions into the register file. It accepts completed results from the memory stage over a valid/ready handshake. For loads it waits for the data-memory response, then aligns and sign/zero-extends the returned word. It drives the register-file write port from registered outputs, so the register file, which samples on the falling clock edge, sees stable write data for half a cycle and a same-cycle read returns the new value.

## Interface
Parameters:
- TIMEOUT, 16, maximum number of cycles to wait for a load response before aborting; must be ≥ 2.

Ports:
- Clock and reset: one clock, `clk`; reset `nrst` is asynchronous and active-low.
- clk  in  1  system clock, rising-edge logic.
- nrst  in  1  asynchronous active-low reset.
- in_valid  in  1  memory stage presents an instruction to retire.
- in_ready  out  1  stage can accept; high in IDLE only.
- in_rd  in  5  destination register.
- in_is_load  in  1  instruction is a load; in_result is ignored.
- in_funct3  in  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- in_addr_lo  in  2  load address bits [1:0].
- in_result  in  32  ALU/CSR/jump-link result for non-loads.
- dmem_rvalid  in  1  load data valid this cycle.
- dmem_rdata  in  32  raw aligned word from data memory.
- rf_wen  out  1  register-file write enable (registered).
- rf_wsel  out  5  register-file write select (registered).
- rf_wdat  out  32  register-file write data (registered).
- pending_valid  out  1  a load to a nonzero rd is outstanding.
- pending_rd  out  5  rd of the outstanding load; 0 when none.
- bus_err  out  1  one-cycle pulse when a load times out.
- retire_count  out  32  count of completed instructions.

## Operation
- States: IDLE, WAIT_LOAD.
- IDLE with in_valid and !in_is_load:
  - Register rd and in_result into rf_* outputs.
  - rf_wen = (in_rd != 0).
  - Stay in IDLE; back-to-back non-loads retire one per cycle.
- IDLE with in_valid and in_is_load:
  - Latch rd, funct3 and addr_lo; clear the timeout counter.
  - Go to WAIT_LOAD; rf_wen = 0 next cycle.
- IDLE without in_valid: rf_wen = 0.
- WAIT_LOAD with dmem_rvalid:
  - rf_wdat = aligned(dmem_rdata); rf_wsel = latched rd; rf_wen = (rd != 0).
  - Return to IDLE.
- WAIT_LOAD without dmem_rvalid:
  - Increment the counter.
  - When the counter reaches TIMEOUT − 1: go to IDLE, pulse bus_err, no write, no retire count.
- Alignment:
  - Byte lane = addr_lo.
  - Half lane = addr_lo[1]; addr_lo[0] is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - funct3 values 011, 110 and 111 are treated as LW.
- dmem_rvalid in IDLE is ignored, including a late response after a timeout.
- rd = 0: the instruction still retires and still waits for the load response; it never writes.
- retire_count increments on every completed retire (non-load accept, or load response) and wraps 0xFFFFFFFF → 0.
- pending_valid = (state == WAIT_LOAD) && rd != 0; pending_rd = the latched rd when pending_valid, else 0.

## Timing
- Reset values: state IDLE, rf_wen 0, rf_wsel 0, rf_wdat 0, bus_err 0, counter 0, retire_count 0.
- in_ready is 1 out of reset (combinational from state).
- Non-load accepted at rising edge N: rf_wen is high from edge N until edge N+1. The register file writes at the intervening falling edge.
- Load accepted at edge N: in_ready = 0 from edge N.
- Load response sampled at edge M ≥ N+1: rf write during cycle M→M+1; in_ready = 1 from edge M.
- Minimum load latency through the stage is 2 cycles (accept to write).
- Timeout: with no dmem_rvalid at edges N+1 … N+TIMEOUT, the return to IDLE and the bus_err pulse both occur at edge N+TIMEOUT.
- dmem_rvalid at edge N+TIMEOUT itself completes the load normally; the response wins over the timeout.
- Reset during WAIT_LOAD: immediately IDLE, pending cleared, no write.

## Structure
- common_types_pkg additions:
  - load_type_t enum (LB, LH, LW, LBU, LHU).
  - wb_state_t (IDLE, WAIT_LOAD).
  - Reuse of word_t and regbits_t.
- Sub-module `load_align`: purely combinational. Inputs: word, funct3, addr_lo. Output: extended word.
- The register-file write port is driven through the existing register_file_if, using a writeback modport.

## Test plan
- Non-load stream: in_result 0xA, 0xB, 0xC to x1, x2, x3 on consecutive cycles → three consecutive rf writes; retire_count 3; in_ready stays 1.
- Loads on dmem_rdata 0x8091A2B3:
  - LB, addr_lo 0 → 0xFFFFFFB3.
  - LBU, addr_lo 2 → 0x00000091.
  - LH, addr_lo 2 → 0xFFFF8091.
  - LHU, addr_lo 0 → 0x0000A2B3.
  - LW → 0x8091A2B3.
- Load to x0 with the response 3 cycles later → no rf_wen, pending_valid 0, retire_count +1; in_ready low for 3 cycles.
- Timeout, TIMEOUT = 16:
  - No response → bus_err single pulse at edge N+16, no write, retire_count unchanged.
  - A late dmem_rvalid is ignored.
  - Response exactly at edge N+16 → normal write, no bus_err.
- Reset asserted mid-WAIT_LOAD with pending_rd = 5 → all outputs return to reset values asynchronously; a subsequent dmem_rvalid causes no write.
